// File: rtl/instance_norm_stream.sv
// instance_norm_stream: buffers 2**LOG2_N samples, derives mean/std, replays (x-mean)/std saturated (optional affine: INSTANCE_NORM_AFFINE_EN).
// Latency: last input handshake to first out_valid is 4+DATA_W+2*FRAC cycles, one more with INSTANCE_NORM_AFFINE_EN.
// Backpressure: in_ready only while accumulating; output pipeline freezes while out_valid && !out_ready.
module instance_norm_stream #(
   parameter int DATA_W = 16,
   parameter int FRAC   = 8,
   parameter int LOG2_N = 6,
   parameter int EPS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [DATA_W-1:0] stat_mean,
`ifdef INSTANCE_NORM_AFFINE_EN
   output logic [DATA_W-1:0] stat_std,
   input  logic [DATA_W-1:0] gamma,
   input  logic [DATA_W-1:0] beta
`else
   output logic [DATA_W-1:0] stat_std
`endif
);

   localparam int N      = 2**LOG2_N;
   localparam int SUM_W  = DATA_W + LOG2_N;
   localparam int SQ_W   = 2*DATA_W + LOG2_N;
   localparam int VAR_W  = 2*DATA_W;
   localparam int R_W    = 2*FRAC + 1;
   localparam int P_W    = DATA_W + R_W + 2;
   localparam int A_W    = P_W + DATA_W;
   localparam int STEP_W = $clog2(DATA_W + R_W + 1);

   localparam logic [2:0] ST_ACCUM = 3'd0;
   localparam logic [2:0] ST_STATS = 3'd1;
   localparam logic [2:0] ST_SQRT  = 3'd2;
   localparam logic [2:0] ST_DIV   = 3'd3;
   localparam logic [2:0] ST_EMIT  = 3'd4;

   logic [2:0]               state;
   logic [LOG2_N-1:0]        cnt;
   logic signed [SUM_W-1:0]  sum;
   logic [SQ_W-1:0]          sumsq;
   logic [VAR_W-1:0]         rad;
   logic [DATA_W+1:0]        rem;
   logic [DATA_W-1:0]        root;
   logic [STEP_W-1:0]        step;
   logic [DATA_W-1:0]        drem;
   logic [R_W-1:0]           dq;
   logic [LOG2_N:0]          rd_idx;
   logic [DATA_W-1:0]        buf_mem [N];

   function automatic logic [DATA_W-1:0] sat_dw(input logic signed [A_W-1:0] v);
      logic [A_W-DATA_W:0] hi;
      hi = v[A_W-1:DATA_W-1];
      if (&hi || ~|hi)
         return v[DATA_W-1:0];
      else if (v[A_W-1])
         return {1'b1, {(DATA_W-1){1'b0}}};
      else
         return {1'b0, {(DATA_W-1){1'b1}}};
   endfunction

   // accumulate
   logic signed [DATA_W-1:0] x_in;
   logic signed [VAR_W-1:0]  x_w, x_sq;
   assign x_in = in_data;
   assign x_w  = VAR_W'(x_in);
   assign x_sq = x_w * x_w;

   // statistics; a floored mean can make the raw variance slightly negative
   logic signed [DATA_W-1:0] mean_w;
   logic signed [VAR_W-1:0]  mean_x, mean_sq;
   logic [SQ_W-1:0]          msq;
   logic signed [SQ_W:0]     var_d;
   logic [VAR_W-1:0]         var_c;
   assign mean_w  = DATA_W'(sum >>> LOG2_N);
   assign mean_x  = VAR_W'(mean_w);
   assign mean_sq = mean_x * mean_x;
   assign msq     = sumsq >> LOG2_N;
   assign var_d   = $signed({1'b0, msq}) - (SQ_W+1)'(mean_sq);
   assign var_c   = var_d[SQ_W] ? '0 : VAR_W'(var_d) + VAR_W'(EPS);

   // restoring square root, two radicand bits per step
   logic [DATA_W+3:0] rem_n, trial, rem_sub;
   logic              sq_ge;
   assign rem_n   = {rem, rad[VAR_W-1 -: 2]};
   assign trial   = {2'b00, root, 2'b01};
   assign sq_ge   = rem_n >= trial;
   assign rem_sub = rem_n - trial;

   // restoring division 2^(2*FRAC) / std; dq shifts dividend out and quotient in
   logic [DATA_W:0]   drem_n, drem_sub;
   logic              dv_ge;
   assign drem_n   = {drem, dq[R_W-1]};
   assign dv_ge    = drem_n >= {1'b0, stat_std};
   assign drem_sub = drem_n - {1'b0, stat_std};

   // replay
   logic signed [DATA_W-1:0] x_rd;
   logic signed [DATA_W:0]   diff;
   logic signed [P_W-1:0]    diff_x, rcp_x, prod, ysh;
   logic                     adv, load, last_rd, last_hs;
   assign x_rd    = buf_mem[rd_idx[LOG2_N-1:0]];
   assign diff    = (DATA_W+1)'(x_rd) - (DATA_W+1)'($signed(stat_mean));
   assign diff_x  = P_W'(diff);
   assign rcp_x   = P_W'($signed({1'b0, dq}));
   assign prod    = diff_x * rcp_x;
   assign ysh     = prod >>> FRAC;
   assign adv     = !out_valid || out_ready;
   assign load    = (state == ST_EMIT) && !rd_idx[LOG2_N];
   assign last_rd = (rd_idx[LOG2_N-1:0] == '1);
   assign last_hs = out_valid && out_ready && out_last;

   assign in_ready = (state == ST_ACCUM);

`ifdef INSTANCE_NORM_AFFINE_EN
   logic [DATA_W-1:0]     gamma_q, beta_q;
   logic                  s1_vld, s1_last;
   logic signed [P_W-1:0] s1_dat;
   logic signed [A_W-1:0] aff_mul, aff_sum;
   assign aff_mul = A_W'(s1_dat) * A_W'($signed(gamma_q));
   assign aff_sum = (aff_mul >>> FRAC) + A_W'($signed(beta_q));
`endif

   always_ff @(posedge clk) begin
      if (in_valid && in_ready)
         buf_mem[cnt] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_ACCUM;
         cnt       <= '0;
         sum       <= '0;
         sumsq     <= '0;
         rad       <= '0;
         rem       <= '0;
         root      <= '0;
         step      <= '0;
         drem      <= '0;
         dq        <= '0;
         rd_idx    <= '0;
         stat_mean <= '0;
         stat_std  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
`ifdef INSTANCE_NORM_AFFINE_EN
         gamma_q   <= '0;
         beta_q    <= '0;
         s1_vld    <= 1'b0;
         s1_last   <= 1'b0;
         s1_dat    <= '0;
`endif
      end else begin
         case (state)
            ST_ACCUM: if (in_valid) begin
               cnt   <= cnt + 1'b1;
               sum   <= sum + SUM_W'(x_in);
               sumsq <= sumsq + SQ_W'(x_sq);
               if (cnt == '1)
                  state <= ST_STATS;
            end
            ST_STATS: begin
               stat_mean <= mean_w;
               rad       <= var_c;
               rem       <= '0;
               root      <= '0;
               step      <= '0;
               state     <= ST_SQRT;
            end
            ST_SQRT: begin
               rad  <= rad << 2;
               rem  <= sq_ge ? (DATA_W+2)'(rem_sub) : (DATA_W+2)'(rem_n);
               root <= {root[DATA_W-2:0], sq_ge};
               step <= step + 1'b1;
               if (step == STEP_W'(DATA_W-1)) begin
                  stat_std <= {root[DATA_W-2:0], sq_ge};
                  drem     <= '0;
                  dq       <= {1'b1, {(R_W-1){1'b0}}};
                  step     <= '0;
                  state    <= ST_DIV;
               end
            end
            ST_DIV: begin
               drem <= dv_ge ? DATA_W'(drem_sub) : DATA_W'(drem_n);
               dq   <= {dq[R_W-2:0], dv_ge};
               step <= step + 1'b1;
               if (step == STEP_W'(R_W-1)) begin
                  rd_idx <= '0;
                  state  <= ST_EMIT;
`ifdef INSTANCE_NORM_AFFINE_EN
                  gamma_q <= gamma;
                  beta_q  <= beta;
`endif
               end
            end
            ST_EMIT: if (last_hs) begin
               cnt   <= '0;
               sum   <= '0;
               sumsq <= '0;
               state <= ST_ACCUM;
            end
            default: state <= ST_ACCUM;
         endcase

`ifdef INSTANCE_NORM_AFFINE_EN
         if (adv) begin
            s1_vld <= load;
            if (load) begin
               s1_dat  <= ysh;
               s1_last <= last_rd;
            end
            out_valid <= s1_vld;
            out_last  <= s1_vld && s1_last;
            if (s1_vld)
               out_data <= sat_dw(aff_sum);
         end
`else
         if (adv) begin
            out_valid <= load;
            out_last  <= load && last_rd;
            if (load)
               out_data <= sat_dw(A_W'(ysh));
         end
`endif
         if (adv && load)
            rd_idx <= rd_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_instance_norm_stream.sv
// Bench for instance_norm_stream: directed instances, scoreboard of expected outputs, immediate-assert checks.
module tb_instance_norm_stream;
   localparam int DW = 16;
   localparam int N  = 64;
`ifdef INSTANCE_NORM_AFFINE_EN
   localparam int Y_CONST = 128;
   localparam int Y_POS   = 640;
   localparam int Y_NEG   = -384;
   localparam int LAT     = 37;
`else
   localparam int Y_CONST = 0;
   localparam int Y_POS   = 256;
   localparam int Y_NEG   = -256;
   localparam int LAT     = 36;
`endif

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, out_valid, out_ready, out_last;
   logic [DW-1:0] in_data, out_data, stat_mean, stat_std;
`ifdef INSTANCE_NORM_AFFINE_EN
   logic [DW-1:0] gamma, beta;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int first_vld_cyc = -1;
   bit rnd_en = 1'b0;
   bit lat_armed = 1'b0;
   bit prev_last_hs = 1'b0;
   logic [DW:0] sbq [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   instance_norm_stream dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .stat_mean (stat_mean),
`ifdef INSTANCE_NORM_AFFINE_EN
      .stat_std  (stat_std),
      .gamma     (gamma),
      .beta      (beta)
`else
      .stat_std  (stat_std)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard monitor: peeks while stalled, pops on handshake
   always @(negedge clk) begin
      if (prev_last_hs)
         check("in_ready_after_last", 32'(in_ready), 1);
      prev_last_hs = 1'b0;
      if (lat_armed && out_valid) begin
         first_vld_cyc = cyc;
         lat_armed = 1'b0;
      end
      if (out_valid) begin
         check("in_ready_while_emit", 32'(in_ready), 0);
         check("sb_pending", 32'(sbq.size() != 0), 1);
         if (sbq.size() != 0) begin
            check("out_last_data", 32'({out_last, out_data}), 32'(sbq[0]));
            if (out_ready) begin
               prev_last_hs = out_last;
               void'(sbq.pop_front());
            end
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic send(input logic [DW-1:0] v, input bit gap);
      int g = 0;
      in_data  = v;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (g >= 500)
         check("in_ready_timeout", 32'(in_ready), 1);
      hs_cyc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input bit alt);
      for (int i = 0; i < N; i++) begin
         logic [DW-1:0] d;
         d = alt ? ((i % 2 == 0) ? DW'(Y_POS) : DW'(Y_NEG)) : DW'(Y_CONST);
         sbq.push_back({i == N-1, d});
      end
   endtask

   task automatic send_const();
      for (int i = 0; i < N; i++) send(16'd256, 1'b0);
   endtask

   task automatic send_alt(input bit gaps);
      for (int i = 0; i < N; i++)
         send((i % 2 == 0) ? 16'h0100 : 16'hFF00, gaps && (i % 3 == 2));
   endtask

   task automatic drain();
      int g = 0;
      @(negedge clk);
      while ((sbq.size() != 0 || out_valid) && g < 3000) begin
         @(negedge clk);
         g++;
      end
      check("drain", 32'(sbq.size()), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int g;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
`ifdef INSTANCE_NORM_AFFINE_EN
      gamma = 16'd512;
      beta  = 16'd128;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_stat_mean", 32'(stat_mean), 0);
      check("rst_stat_std", 32'(stat_std), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // constant 1.0 instance
      push_exp(1'b0);
      send_const();
      drain();
      check("const_mean", 32'(stat_mean), 256);
      check("const_std", 32'(stat_std), 1);

      // alternating +-1.0 with input gaps; first-output latency
      push_exp(1'b1);
      send_alt(1'b1);
      lat_armed = 1'b1;
      drain();
      check("alt_latency", 32'(first_vld_cyc - hs_cyc), LAT);
      check("alt_mean", 32'(stat_mean), 0);
      check("alt_std", 32'(stat_std), 256);

      // random output backpressure
      rnd_en = 1'b1;
      push_exp(1'b1);
      send_alt(1'b0);
      drain();
      rnd_en = 1'b0;
      @(posedge clk);
      #1;

      // reset after 20 stale samples, then a clean constant instance
      for (int i = 0; i < 20; i++) send(16'h0500, 1'b0);
      pulse_reset();
      push_exp(1'b0);
      send_const();
      drain();
      check("rst_mid_mean", 32'(stat_mean), 256);
      check("rst_mid_std", 32'(stat_std), 1);

      // reset while computing the square root
      send_alt(1'b0);
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      pulse_reset();
      @(negedge clk);
      check("rst_sqrt_out_valid", 32'(out_valid), 0);
      check("rst_sqrt_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;

      // reset while emitting
      push_exp(1'b1);
      send_alt(1'b0);
      g = 0;
      while (sbq.size() > 40 && g < 2000) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("emit_progress", 32'(sbq.size() <= 40), 1);
      pulse_reset();
      sbq.delete();
      @(negedge clk);
      check("rst_emit_out_valid", 32'(out_valid), 0);
      check("rst_emit_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;

      // recovery after reset
      push_exp(1'b1);
      send_alt(1'b0);
      drain();
      check("recover_std", 32'(stat_std), 256);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
